// File: rtl/edge_detect_multi_amisha.sv
// Multi-channel synchronised edge detector with per-channel mode, sticky pending flags and a
// saturating event counter. Define EDGE_DEBOUNCE_EN to add per-channel debounce (RISE_WAIT/FALL_WAIT).
module edge_detect_multi_amisha #(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int COUNT_W     = 8,
  parameter int DB_CYCLES   = 4
) (
  input  logic                 clk_amisha,
  input  logic                 reset_n_amisha,
  input  logic [CH-1:0]        level_amisha,
  input  logic [2*CH-1:0]      mode_amisha,
  input  logic [CH-1:0]        clr_amisha,
  input  logic                 count_clr_amisha,
  output logic [CH-1:0]        tick_amisha,
  output logic [CH-1:0]        dir_amisha,
  output logic [CH-1:0]        pend_amisha,
  output logic                 any_tick_amisha,
  output logic [COUNT_W-1:0]   count_amisha,
  output logic [2*CH-1:0]      fsm_state_amisha
);

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_RISE_WAIT = 2'd1,
    ST_HIGH      = 2'd2,
    ST_FALL_WAIT = 2'd3
  } state_t;

  localparam int SUM_W = COUNT_W + $clog2(CH + 1);
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  if (CH < 1 || SYNC_STAGES < 2 || DB_CYCLES < 1) begin : g_param_check
    $error("edge_detect_multi_amisha: illegal parameter value");
  end

  logic [CH-1:0]      sync_q [SYNC_STAGES];
  logic [CH-1:0]      s;
  state_t             state_q [CH];
  state_t             state_d [CH];
  logic [CH-1:0]      rise_d, fall_d, tick_d, dir_d, pend_d;
  logic [SUM_W-1:0]   pop_d, sum_d;
  logic [COUNT_W-1:0] count_d;

`ifdef EDGE_DEBOUNCE_EN
  localparam int DB_W = $clog2(DB_CYCLES + 1);
  logic [DB_W-1:0] db_q [CH];
  logic [DB_W-1:0] db_d [CH];
`endif

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_amisha or negedge reset_n_amisha) begin
    if (!reset_n_amisha) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= level_amisha;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  // The FSM tracks the level unconditionally; mode only qualifies what gets reported.
  always_comb begin
    rise_d = '0;
    fall_d = '0;
    tick_d = '0;
    dir_d  = '0;
    for (int i = 0; i < CH; i++) begin
      state_d[i] = state_q[i];
`ifdef EDGE_DEBOUNCE_EN
      db_d[i] = db_q[i];
`endif
      case (state_q[i])
        ST_LOW: begin
          if (s[i]) begin
`ifdef EDGE_DEBOUNCE_EN
            if (DB_CYCLES == 1) begin
              state_d[i] = ST_HIGH;
              rise_d[i]  = 1'b1;
            end else begin
              state_d[i] = ST_RISE_WAIT;
              db_d[i]    = DB_W'(1);
            end
`else
            state_d[i] = ST_HIGH;
            rise_d[i]  = 1'b1;
`endif
          end
        end
        ST_HIGH: begin
          if (!s[i]) begin
`ifdef EDGE_DEBOUNCE_EN
            if (DB_CYCLES == 1) begin
              state_d[i] = ST_LOW;
              fall_d[i]  = 1'b1;
            end else begin
              state_d[i] = ST_FALL_WAIT;
              db_d[i]    = DB_W'(1);
            end
`else
            state_d[i] = ST_LOW;
            fall_d[i]  = 1'b1;
`endif
          end
        end
`ifdef EDGE_DEBOUNCE_EN
        ST_RISE_WAIT: begin
          if (!s[i]) begin
            state_d[i] = ST_LOW;
            db_d[i]    = '0;
          end else if (db_q[i] + DB_W'(1) == DB_W'(DB_CYCLES)) begin
            state_d[i] = ST_HIGH;
            db_d[i]    = '0;
            rise_d[i]  = 1'b1;
          end else begin
            db_d[i] = db_q[i] + DB_W'(1);
          end
        end
        ST_FALL_WAIT: begin
          if (s[i]) begin
            state_d[i] = ST_HIGH;
            db_d[i]    = '0;
          end else if (db_q[i] + DB_W'(1) == DB_W'(DB_CYCLES)) begin
            state_d[i] = ST_LOW;
            db_d[i]    = '0;
            fall_d[i]  = 1'b1;
          end else begin
            db_d[i] = db_q[i] + DB_W'(1);
          end
        end
`endif
        default: state_d[i] = ST_LOW;
      endcase
      tick_d[i] = (rise_d[i] & mode_amisha[2*i]) | (fall_d[i] & mode_amisha[2*i+1]);
      dir_d[i]  = rise_d[i] & mode_amisha[2*i];
    end
  end

  // Set wins over clear so an event arriving with a clear is never lost.
  always_comb begin
    pend_d = (pend_amisha & ~clr_amisha) | tick_d;
    pop_d  = '0;
    for (int i = 0; i < CH; i++) pop_d = pop_d + SUM_W'(tick_d[i]);
    sum_d  = (count_clr_amisha ? '0 : SUM_W'(count_amisha)) + pop_d;
    count_d = (sum_d > SUM_W'(CNT_MAX)) ? CNT_MAX : sum_d[COUNT_W-1:0];
  end

  always_ff @(posedge clk_amisha or negedge reset_n_amisha) begin
    if (!reset_n_amisha) begin
      for (int i = 0; i < CH; i++) begin
        state_q[i] <= ST_LOW;
`ifdef EDGE_DEBOUNCE_EN
        db_q[i] <= '0;
`endif
      end
      tick_amisha     <= '0;
      dir_amisha      <= '0;
      pend_amisha     <= '0;
      any_tick_amisha <= 1'b0;
      count_amisha    <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        state_q[i] <= state_d[i];
`ifdef EDGE_DEBOUNCE_EN
        db_q[i] <= db_d[i];
`endif
      end
      tick_amisha     <= tick_d;
      dir_amisha      <= dir_d;
      pend_amisha     <= pend_d;
      any_tick_amisha <= |tick_d;
      count_amisha    <= count_d;
    end
  end

  always_comb begin
    fsm_state_amisha = '0;
    for (int i = 0; i < CH; i++) fsm_state_amisha[2*i +: 2] = state_q[i];
  end

endmodule
